// File: rtl/tetris_pkg.sv
// Shared types and default widths for the image-memory arbiter slice.
package tetris_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_Q_W    = 32;
    localparam int STARVE_W   = 4;

    // Each state names the requester that owned port A in the previous cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        BLT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/imgmem_arbiter_if.sv
// Requester and memory-port signals of the image-memory arbiter.
interface imgmem_arbiter_if
    import tetris_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int Q_W    = DEF_Q_W
) ();

    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_gnt;
    logic              cpu_rvalid;

    logic              blt_req;
    logic              blt_wren;
    logic              blt_lock;
    logic [ADDR_W-1:0] blt_addr;
    logic [DATA_W-1:0] blt_data;
    logic              blt_gnt;
    logic              blt_rvalid;

    logic [Q_W-1:0]    rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [Q_W-1:0]    mem_q;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_data,
        input  blt_req, blt_wren, blt_lock, blt_addr, blt_data,
        input  mem_q,
        output cpu_gnt, cpu_rvalid, blt_gnt, blt_rvalid,
        output rdata, mem_addr, mem_data, mem_wren
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_data,
        output blt_req, blt_wren, blt_lock, blt_addr, blt_data,
        output mem_q,
        input  cpu_gnt, cpu_rvalid, blt_gnt, blt_rvalid,
        input  rdata, mem_addr, mem_data, mem_wren
    );

endinterface

// File: rtl/imgmem_starve_ctr.sv
// Saturating count of CPU grants taken while the blitter was waiting.
module imgmem_starve_ctr
    import tetris_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX);

    logic [STARVE_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count < LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count >= LIMIT);

endmodule

// File: rtl/imgmem_arbiter.sv
// CPU/blitter arbiter for image-memory port A; CPU has priority, blitter may lock bursts.
// Defining IMGARB_STARVE_GUARD_EN forces a blitter grant after STARVE_MAX CPU wins.
module imgmem_arbiter
    import tetris_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int Q_W        = DEF_Q_W,
    parameter int STARVE_MAX = 8
) (
    input logic             clock,
    input logic             reset,
    imgmem_arbiter_if.slave bus
);

    if ((STARVE_MAX < 1) || (STARVE_MAX >= (1 << STARVE_W))) begin : g_bad_starve_max
        $error("STARVE_MAX must fit the starvation counter");
    end

    arb_state_t        state;
    arb_state_t        state_next;
    logic              cpu_win;
    logic              blt_win;
    logic              any_win;
    logic              read_win;
    logic              starve_hit;
    logic              grant_wren;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic [Q_W-1:0]    rdata_q;
    logic              cpu_rv;
    logic              blt_rv;

`ifdef IMGARB_STARVE_GUARD_EN
    imgmem_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clock  (clock),
        .reset  (reset),
        .inc    (cpu_win & bus.blt_req),
        .clr    (blt_win),
        .at_max (starve_hit)
    );
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are combinational; a locked blitter burst outranks everything, then the starvation override.
    always_comb begin
        state_next = IDLE;
        cpu_win    = 1'b0;
        blt_win    = 1'b0;
        if (reset) begin
            if ((state == BLT) && bus.blt_req && bus.blt_lock) begin
                blt_win = 1'b1;
            end else if (starve_hit && bus.blt_req) begin
                blt_win = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_win = 1'b1;
            end else if (bus.blt_req) begin
                blt_win = 1'b1;
            end
            if (cpu_win) begin
                state_next = CPU;
            end else if (blt_win) begin
                state_next = BLT;
            end
        end
    end

    assign any_win    = cpu_win | blt_win;
    assign grant_addr = cpu_win ? bus.cpu_addr : bus.blt_addr;
    assign grant_data = cpu_win ? bus.cpu_data : bus.blt_data;
    assign grant_wren = cpu_win ? bus.cpu_wren : bus.blt_wren;
    assign read_win   = any_win & ~grant_wren;

    // Idle cycles keep presenting the last granted address and data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_addr <= '0;
            last_data <= '0;
            rdata_q   <= '0;
            cpu_rv    <= 1'b0;
            blt_rv    <= 1'b0;
        end else begin
            if (any_win) begin
                last_addr <= grant_addr;
                last_data <= grant_data;
            end
            if (read_win) begin
                rdata_q <= bus.mem_q;
            end
            cpu_rv <= cpu_win & ~bus.cpu_wren;
            blt_rv <= blt_win & ~bus.blt_wren;
        end
    end

    assign bus.mem_addr   = any_win ? grant_addr : last_addr;
    assign bus.mem_data   = any_win ? grant_data : last_data;
    assign bus.mem_wren   = any_win & grant_wren;
    assign bus.cpu_gnt    = cpu_win;
    assign bus.blt_gnt    = blt_win;
    assign bus.cpu_rvalid = cpu_rv;
    assign bus.blt_rvalid = blt_rv;
    assign bus.rdata      = rdata_q;

endmodule
